// File: rtl/enc164_pkg.sv
// Shared constants, state encoding and helpers for the 16-to-4 request scanner.
// Combinational helpers only; no latency of their own.
// No flow control here; users own all handshaking.
package enc164_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  // Scanner control states: wait for a load, pick the next index, hold it for the consumer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    HOLD = 2'd2
  } enc_state_t;

  // Number of set bits in a request vector (0..16, hence IDX_W+1 bits).
  function automatic logic [IDX_W:0] popcount16(input logic [N_REQ-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // One-hot mask for a 4-bit index, used to retire a served request.
  function automatic logic [N_REQ-1:0] idx_mask(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pri_enc16.sv
// Lowest-set-bit priority encoder over 16 requests; 'any' flags a nonzero vector.
// Purely combinational, zero cycles.
// No backpressure; output follows input every cycle.
module pri_enc16
  import enc164_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written and wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc164_scan.sv
// Sequential 16-to-4 encoder: captures a request vector and emits each set index once.
// Load to first valid index is 2 cycles; one index per 2 cycles at best.
// out_idx/out_valid/out_last hold steady while out_ready is low; load ignored while busy.
// Optional round-robin start point is enabled by defining ENC164_ROUND_ROBIN_EN.
module enc164_scan
  import enc164_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_req,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        done
);

  enc_state_t       state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  // Encoder view of the pending set and the absolute index it resolves to.
  logic [N_REQ-1:0] enc_req;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [IDX_W-1:0] sel_idx;

`ifdef ENC164_ROUND_ROBIN_EN
  // Last index handed out; the next search begins just above it.
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] start;

  // Rotate pending right by ptr+1 so the encoder's bit 0 is the search start point.
  always_comb begin
    start = ptr_q + IDX_W'(1);
    for (int i = 0; i < N_REQ; i++) begin
      enc_req[i] = pending_q[IDX_W'(i) + start];
    end
  end

  // Undo the rotation; 4-bit addition wraps past 15 back to 0.
  assign sel_idx = enc_idx + start;
`else
  assign enc_req = pending_q;
  assign sel_idx = enc_idx;
`endif

  pri_enc16 u_pri_enc16 (
    .req (enc_req),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Next-state and next-output decode for the load / select / hold sequence.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
`ifdef ENC164_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          if (in_req != '0) begin
            pending_d = in_req;
            state_d   = SEL;
          end else begin
            // Nothing to serve: acknowledge the load straight away.
            done_d = 1'b1;
          end
        end
      end
      SEL: begin
        if (enc_any) begin
          idx_d   = sel_idx;
          valid_d = 1'b1;
          last_d  = (popcount16(pending_q) == (IDX_W + 1)'(1));
          state_d = HOLD;
        end else begin
          // Unreachable with a consistent pending set; recover to IDLE cleanly.
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          pending_d = pending_q & ~idx_mask(idx_q);
          valid_d   = 1'b0;
          last_d    = 1'b0;
`ifdef ENC164_ROUND_ROBIN_EN
          ptr_d     = idx_q;
`endif
          if (pending_d != '0) begin
            state_d = SEL;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // All state and registered outputs; reset discards pending work without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ENC164_ROUND_ROBIN_EN
      ptr_q     <= 4'd15;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
`ifdef ENC164_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule

// File: doc/enc164_scan.md
# enc164_scan

Sequential 16-to-4 encoder, the inverse of the dec416 one-hot decoder. It captures a 16-bit request vector on a load pulse and emits the index of every set bit, one per valid/ready handshake, clearing each bit as it is served. It sits between request sources (switches, interrupt-style flags) and index consumers such as the 7-segment digit path.

## Interface
- No parameters. Width is fixed: 16 requests, 4-bit index.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_req` input 16: request vector, sampled only on an accepted load.
- `load` input 1: capture request; accepted only in IDLE.
- `busy` output 1: high in any state other than IDLE.
- `out_idx` output 4: index of the bit being served.
- `out_valid` output 1: `out_idx` is valid.
- `out_ready` input 1: consumer accepts `out_idx`.
- `out_last` output 1: high with `out_valid` when this is the final pending bit.
- `done` output 1: one-cycle pulse when a load has been fully served.

## Operation
- States:
  - IDLE: if `load` and `in_req != 0`, capture `pending <= in_req` and go to SEL. If `load` and `in_req == 0`, pulse `done` next cycle and stay in IDLE.
  - SEL: priority-encode `pending`, register `out_idx`, set `out_valid <= 1`, set `out_last <= (popcount(pending) == 1)`, go to HOLD.
  - HOLD: `out_idx`, `out_valid` and `out_last` are held stable until `out_valid && out_ready`. On that handshake:
    - clear bit `out_idx` in `pending` and drop `out_valid`/`out_last`;
    - if the remaining `pending != 0`, go to SEL;
    - else go to IDLE and pulse `done`.
- Default selection is the lowest set index first.
- `load` outside IDLE is ignored; `in_req` is a don't-care there.
- `out_ready` high while `out_valid` is low has no effect.
- Reset values: state IDLE, `pending` 0, `out_idx` 0, `out_valid` 0, `out_last` 0, `done` 0, `busy` 0, round-robin pointer 15.
- Reset mid-operation: all pending requests are discarded and the block returns to IDLE immediately. No `done` pulse.

## Timing
- Load accepted at edge E0 → SEL during the following cycle → `out_valid` high after edge E1. Latency is 2 cycles.
- Handshake at edge Eh:
  - `out_valid` is low for exactly one cycle (SEL);
  - the next index is valid after edge Eh+1;
  - maximum throughput is one index per 2 cycles.
- `done` is high for the single cycle after the final handshake edge, coincident with `busy` low. A new `load` in that same cycle is accepted.
- `busy` goes high the cycle after an accepted load with a nonzero vector.

## Configuration
- `ENC164_ROUND_ROBIN_EN` defined:
  - search starts at `(ptr + 1) mod 16` and wraps past 15 to 0;
  - `ptr` updates to `out_idx` on each handshake;
  - `ptr` persists across loads and is reset only by `reset`.
- `ENC164_ROUND_ROBIN_EN` undefined: fixed lowest-index priority; no `ptr` register.

## Structure
- Package `enc164_pkg`: constants `N_REQ = 16` and `IDX_W = 4`; state enum `enc_state_t` {IDLE, SEL, HOLD}.
- Sub-module `pri_enc16`: combinational lowest-set-bit encoder, with outputs index and `any`.
  - The round-robin build rotates `pending` right by `ptr + 1` before encoding.
  - It then adds `ptr + 1` to the result, mod 16.

## Test plan
- Fixed-priority order: reset, then `load` with `in_req = 16'h8421`, `out_ready = 1`. Expect `out_idx` 0, 5, 10, 15; `out_last` only with 15; `done` pulse; 8 cycles from load to `done`.
- Empty load: `load` with `in_req = 16'h0000`. Expect `done` next cycle; `out_valid` and `busy` stay 0.
- Backpressure: `in_req = 16'h0003`, `out_ready` held 0 for 5 cycles. Expect `out_idx = 0` and `out_valid` held stable; after release, index 1 with `out_last = 1`.
- Ignored load: a `load` with `16'hFFFF` while serving `16'h0010`. Expect only index 4, then `done`.
- Reset mid-operation: `reset` asserted while serving `16'h00F0`, after index 4. Expect all outputs 0 immediately; a later `load 16'h0001` yields index 0.
- `ENC164_ROUND_ROBIN_EN` build:
  - load `16'h0022`, serve index 1, then reset-free reload of `16'h0022`. Expect 5, then 1.
  - load `16'h8001` after `ptr = 15`. Expect 0, then 15.
